// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for seq_chunk_adder.
// The master drives a request and the slave returns the handshake and the result.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with a start/busy/done handshake and results held until the next start.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_chunk_adder_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic [CHUNK:0]   rc;

  assign chunk_a = a_q[count_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[count_q*CHUNK +: CHUNK];
  assign rc[0]   = carry_q;

  // Explicit bitwise ripple so the per-bit carries stay visible for overflow.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ripple
    assign chunk_s[gi] = chunk_a[gi] ^ chunk_b[gi] ^ rc[gi];
    assign rc[gi+1]    = (chunk_a[gi] & chunk_b[gi]) | (chunk_a[gi] & rc[gi]) |
                         (chunk_b[gi] & rc[gi]);
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    count_d    = count_q;
    sum_d      = sum_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtract is a + ~b + ~c_in, i.e. a - b - c_in.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? ~bus.c_in : bus.c_in;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[count_q*CHUNK +: CHUNK] = chunk_s;
        carry_d = rc[CHUNK];
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          c_out_d    = rc[CHUNK];
          overflow_d = rc[CHUNK-1] ^ rc[CHUNK];
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: WIDTH=16 with CHUNK=4 (dut0) and CHUNK=16 (dut1),
// expected results queued at start and compared when done appears.
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) bus0 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus1 ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
  } op_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: full-width arithmetic, overflow from operand/result sign bits.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
    logic [15:0] bb;
    logic        ci;
    logic [16:0] full;
    res_t        r;
    bb   = sub ? ~b : b;
    ci   = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
    r.s  = full[15:0];
    r.c  = full[16];
    r.v  = (a[15] == bb[15]) && (full[15] != a[15]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin);
    bus0.a     = a;
    bus0.b     = b;
    bus0.sub   = sub;
    bus0.c_in  = cin;
    bus0.start = 1'b1;
    sb.push_back(model(a, b, sub, cin));
    $display("op a=%h b=%h sub=%b cin=%b", a, b, sub, cin);
    tick();
    bus0.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus0.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus0.busy, bus0.done, bus0.sum, bus0.c_out, bus0.overflow} !== 20'd0 ||
        {bus1.busy, bus1.done, bus1.sum, bus1.c_out, bus1.overflow} !== 20'd0) begin
      errors++;
      $display("FAIL reset_state: got dut0 %b%b %h %b%b dut1 %b%b %h %b%b, expected all zero",
               bus0.busy, bus0.done, bus0.sum, bus0.c_out, bus0.overflow,
               bus1.busy, bus1.done, bus1.sum, bus1.c_out, bus1.overflow);
    end
  endtask

  task automatic test_add();
    int   cyc;
    res_t e;
    start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    checks++;
    if (bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
      errors++;
      $display("FAIL add_busy: got busy=%b done=%b, expected busy=1 done=0", bus0.busy, bus0.done);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL add_latency: got %0d cycles, expected 4", cyc);
    end
    e = sb.pop_front();
    checks++;
    if ({bus0.sum, bus0.c_out, bus0.overflow} !== e || bus0.busy !== 1'b0 || e.s !== 16'h2233) begin
      errors++;
      $display("FAIL add_result: got sum=%h c=%b v=%b busy=%b, expected sum=%h c=%b v=%b busy=0",
               bus0.sum, bus0.c_out, bus0.overflow, bus0.busy, e.s, e.c, e.v);
    end
    $display("result sum=%h c=%b v=%b", bus0.sum, bus0.c_out, bus0.overflow);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || {bus0.sum, bus0.c_out, bus0.overflow} !== e) begin
        errors++;
        $display("FAIL add_hold: got done=%b busy=%b sum=%h c=%b v=%b, expected 0 0 %h %b %b",
                 bus0.done, bus0.busy, bus0.sum, bus0.c_out, bus0.overflow, e.s, e.c, e.v);
      end
    end
  endtask

  task automatic test_arith();
    op_t  ops[6];
    int   cyc;
    res_t e;
    ops[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0};
    ops[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1};
    ops[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0};
    ops[3] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0};
    ops[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0};
    ops[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1};
    foreach (ops[i]) begin
      start_op(ops[i].a, ops[i].b, ops[i].sub, ops[i].cin);
      wait_done(cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== 4 || {bus0.sum, bus0.c_out, bus0.overflow} !== e) begin
        errors++;
        $display("FAIL arith_%0d: got sum=%h c=%b v=%b after %0d cycles, expected sum=%h c=%b v=%b after 4",
                 i, bus0.sum, bus0.c_out, bus0.overflow, cyc, e.s, e.c, e.v);
      end
      $display("result sum=%h c=%b v=%b", bus0.sum, bus0.c_out, bus0.overflow);
      tick();
    end
  endtask

  task automatic test_handshake();
    int   cyc;
    res_t e;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    // Stray start mid-RUN with different operands; nothing pushed.
    bus0.a     = 16'hAAAA;
    bus0.b     = 16'h5555;
    bus0.sub   = 1'b1;
    bus0.c_in  = 1'b1;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 2 || {bus0.sum, bus0.c_out, bus0.overflow} !== e) begin
      errors++;
      $display("FAIL ignore_start: got sum=%h c=%b v=%b after %0d more cycles, expected sum=%h c=%b v=%b after 2",
               bus0.sum, bus0.c_out, bus0.overflow, cyc, e.s, e.c, e.v);
    end
    $display("result sum=%h c=%b v=%b", bus0.sum, bus0.c_out, bus0.overflow);
    tick();
    checks++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: got busy=%b done=%b, expected 0 0", bus0.busy, bus0.done);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    res_t e;
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 4 || {bus0.sum, bus0.c_out, bus0.overflow} !== e) begin
      errors++;
      $display("FAIL b2b_first: got sum=%h c=%b v=%b after %0d, expected sum=%h c=%b v=%b after 4",
               bus0.sum, bus0.c_out, bus0.overflow, cyc, e.s, e.c, e.v);
    end
    start_op(16'h4000, 16'h4000, 1'b0, 1'b1);
    checks++;
    if (bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b, expected 1", bus0.busy);
    end
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc + 1 !== 5 || {bus0.sum, bus0.c_out, bus0.overflow} !== e) begin
      errors++;
      $display("FAIL b2b_second: got sum=%h c=%b v=%b %0d cycles after first done, expected sum=%h c=%b v=%b after 5",
               bus0.sum, bus0.c_out, bus0.overflow, cyc + 1, e.s, e.c, e.v);
    end
    $display("result sum=%h c=%b v=%b", bus0.sum, bus0.c_out, bus0.overflow);
    tick();
  endtask

  task automatic test_reset_mid();
    int   cyc;
    int   seen;
    res_t e;
    start_op(16'h9876, 16'h1357, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_front());
    checks++;
    if ({bus0.busy, bus0.done, bus0.sum, bus0.c_out, bus0.overflow} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b sum=%h c=%b v=%b, expected all zero",
               bus0.busy, bus0.done, bus0.sum, bus0.c_out, bus0.overflow);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus0.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done cycles, expected 0", seen);
    end
    start_op(16'hC3A5, 16'h5A3C, 1'b1, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 4 || {bus0.sum, bus0.c_out, bus0.overflow} !== e) begin
      errors++;
      $display("FAIL reset_recover: got sum=%h c=%b v=%b after %0d, expected sum=%h c=%b v=%b after 4",
               bus0.sum, bus0.c_out, bus0.overflow, cyc, e.s, e.c, e.v);
    end
    $display("result sum=%h c=%b v=%b", bus0.sum, bus0.c_out, bus0.overflow);
    tick();
  endtask

  task automatic test_chunk_full();
    op_t  ops[2];
    res_t e;
    ops[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0};
    ops[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0};
    foreach (ops[i]) begin
      bus1.a     = ops[i].a;
      bus1.b     = ops[i].b;
      bus1.sub   = ops[i].sub;
      bus1.c_in  = ops[i].cin;
      bus1.start = 1'b1;
      sb.push_back(model(ops[i].a, ops[i].b, ops[i].sub, ops[i].cin));
      $display("op1 a=%h b=%h sub=%b cin=%b", ops[i].a, ops[i].b, ops[i].sub, ops[i].cin);
      tick();
      bus1.start = 1'b0;
      checks++;
      if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
        errors++;
        $display("FAIL n1_busy_%0d: got busy=%b done=%b, expected 1 0", i, bus1.busy, bus1.done);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (bus1.done !== 1'b1 || {bus1.sum, bus1.c_out, bus1.overflow} !== e) begin
        errors++;
        $display("FAIL n1_result_%0d: got done=%b sum=%h c=%b v=%b, expected done=1 sum=%h c=%b v=%b",
                 i, bus1.done, bus1.sum, bus1.c_out, bus1.overflow, e.s, e.c, e.v);
      end
      $display("result1 sum=%h c=%b v=%b", bus1.sum, bus1.c_out, bus1.overflow);
      tick();
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus0.start = 1'b0;
    bus0.sub   = 1'b0;
    bus0.a     = '0;
    bus0.b     = '0;
    bus0.c_in  = 1'b0;
    bus1.start = 1'b0;
    bus1.sub   = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    bus1.c_in  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_add();
    test_arith();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_chunk_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
